// File: rtl/simple_fifo_arbiter.sv
// Packet-level round-robin arbiter in front of a narrow-to-wide FIFO adapter write port.
// A grant covers a whole packet (or MAX_PKT_BEATS beats); accepted beats leave through one register.
module simple_fifo_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned MAX_PKT_BEATS = 256
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic [NUM_REQ-1:0]                              req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                   req_dat,
    input  logic [NUM_REQ-1:0]                              req_last,
    output logic [NUM_REQ-1:0]                              req_rdy,
    output logic                                            wr_ena,
    output logic [DATA_WIDTH-1:0]                           wr_dat,
    output logic                                            wr_last,
    input  logic                                            wr_full,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            busy,
    output logic                                            trunc_err
);

    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_PKT_BEATS - 1);
    localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  wr_ena_q, wr_ena_d;
    logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;
    logic                  wr_last_q, wr_last_d;
    logic                  trunc_err_q, trunc_err_d;

    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [IdW-1:0]        pick;
    logic                  at_limit;

    // Only the granted requester's lanes are ever looked at.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IdW'(i)) begin
                sel_vld  = req_vld[i];
                sel_last = req_last[i];
                sel_dat  = req_dat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First pass finds the lowest valid index overall (the wrap-around case); the second pass
    // overrides it with the lowest valid index at or above rr_ptr when one exists.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vld[i]) pick = IdW'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vld[i] && (IdW'(i) >= rr_ptr_q)) pick = IdW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = (state_q == StXfer) && (grant_q == IdW'(i)) && !wr_full;
        end
    end

    assign at_limit = (beat_cnt_q == LastCnt);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        wr_ena_d    = 1'b0;
        wr_dat_d    = wr_dat_q;
        wr_last_d   = 1'b0;
        trunc_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_vld) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                if (sel_vld && !wr_full) begin
                    wr_ena_d    = 1'b1;
                    wr_dat_d    = sel_dat;
                    wr_last_d   = sel_last | at_limit;
                    trunc_err_d = at_limit & ~sel_last;
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    if (sel_last || at_limit) begin
                        state_d  = StIdle;
                        rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            wr_ena_q    <= 1'b0;
            wr_dat_q    <= '0;
            wr_last_q   <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_ena_q    <= wr_ena_d;
            wr_dat_q    <= wr_dat_d;
            wr_last_q   <= wr_last_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign wr_ena    = wr_ena_q;
    assign wr_dat    = wr_dat_q;
    assign wr_last   = wr_last_q;
    assign trunc_err = trunc_err_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == StXfer);

endmodule

// File: tb/tb_simple_fifo_arbiter.sv
// Bench for simple_fifo_arbiter: directed scenarios plus randomized traffic, all checked
// against a packet-level reference model; a second 3-requester instance covers pointer wrap.
module tb_simple_fifo_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int MAXB = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_vld, req_last, req_rdy;
    logic [NREQ*DW-1:0]   req_dat;
    logic                 wr_ena, wr_last, wr_full, busy, trunc_err;
    logic [DW-1:0]        wr_dat;
    logic [1:0]           grant_id;

    logic                 rst3n, wr_full3, wr_ena3, wr_last3, busy3, trunc3;
    logic [2:0]           vld3, last3, rdy3;
    logic [3*DW-1:0]      dat3;
    logic [DW-1:0]        wr_dat3;
    logic [1:0]           gid3;

    always #5 clk = ~clk;

    simple_fifo_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB)) u_dut (
        .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_dat(req_dat), .req_last(req_last),
        .req_rdy(req_rdy), .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_last(wr_last),
        .wr_full(wr_full), .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
    );

    simple_fifo_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_PKT_BEATS(8)) u_dut3 (
        .clk(clk), .rstn(rst3n), .req_vld(vld3), .req_dat(dat3), .req_last(last3),
        .req_rdy(rdy3), .wr_ena(wr_ena3), .wr_dat(wr_dat3), .wr_last(wr_last3),
        .wr_full(wr_full3), .grant_id(gid3), .busy(busy3), .trunc_err(trunc3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner of the port (-1 when nobody holds it), beats taken, next start point.
    int          m_owner = -1;
    int          m_gid   = 0;
    int          m_cnt   = 0;
    int          m_ptr   = 0;
    bit          e_ena, e_last, e_trunc, e_dat_chk;
    logic [DW-1:0] e_dat;

    task automatic model_update(output int acc_r);
        bit lim;
        bit lst;
        acc_r     = -1;
        e_ena     = 0;
        e_last    = 0;
        e_trunc   = 0;
        e_dat_chk = 0;
        if (!rstn) begin
            m_owner   = -1;
            m_gid     = 0;
            m_cnt     = 0;
            m_ptr     = 0;
            e_dat     = '0;
            e_dat_chk = 1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req_vld[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_gid   = m_owner;
                    m_cnt   = 0;
                end
            end
        end else if (req_vld[m_owner] && !wr_full) begin
            acc_r     = m_owner;
            lim       = (m_cnt == MAXB - 1);
            lst       = req_last[m_owner];
            e_ena     = 1;
            e_dat     = req_dat[m_owner*DW +: DW];
            e_dat_chk = 1;
            e_last    = lst || lim;
            e_trunc   = lim && !lst;
            m_cnt++;
            if (lst || m_cnt == MAXB) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_owner >= 0 && !wr_full) exp_rdy[m_owner] = 1'b1;
        check_eq("req_rdy", req_rdy, exp_rdy);
        check_eq("wr_ena", wr_ena, e_ena);
        if (e_dat_chk) check_eq("wr_dat", wr_dat, e_dat);
        check_eq("wr_last", wr_last, e_last);
        check_eq("trunc_err", trunc_err, e_trunc);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("busy", busy, m_owner >= 0);
    endtask

    // Sources: beats left in the current packet and the next data word per requester.
    int          src_left [NREQ];
    logic [DW-1:0] src_next [NREQ];
    int          vld_pct = 100, full_pct = 0, refill_len = 0;
    int          full_lo = -1, full_hi = -1, rst_cyc = -1;
    bit          rand_mode = 0, force_rst = 0;

    int          tcyc = 0;
    bit          prev_busy = 0;
    logic [63:0] ena_h, last_h, busy_h;
    int          gid_h [64];
    logic [NREQ-1:0] rdy_h [64];
    logic [17:0] out_q [$];
    logic [17:0] exp_q [$];
    int          grant_q [$];

    task automatic cycle();
        int acc_r;
        for (int i = 0; i < NREQ; i++) begin
            if (src_left[i] == 0) begin
                if (refill_len > 0) src_left[i] = refill_len;
                else if (rand_mode && $urandom_range(99) < 30) src_left[i] = $urandom_range(7, 1);
            end
        end
        rstn = !(force_rst || tcyc == rst_cyc || (rand_mode && $urandom_range(999) < 4));
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i]  = (src_left[i] > 0) && ($urandom_range(99) < vld_pct);
            req_last[i] = (src_left[i] == 1);
            req_dat[i*DW +: DW] = req_vld[i] ? src_next[i] : DW'($urandom);
        end
        wr_full = (tcyc >= full_lo && tcyc <= full_hi) || ($urandom_range(99) < full_pct);
        #1;
        check_outputs();
        if (tcyc < 64) begin
            ena_h[tcyc]  = wr_ena;
            last_h[tcyc] = wr_last;
            busy_h[tcyc] = busy;
            gid_h[tcyc]  = grant_id;
            rdy_h[tcyc]  = req_rdy;
        end
        if (wr_ena) out_q.push_back({trunc_err, wr_last, wr_dat});
        if (busy && !prev_busy) grant_q.push_back(grant_id);
        prev_busy = busy;
        model_update(acc_r);
        if (acc_r >= 0) begin
            src_next[acc_r] = src_next[acc_r] + 1'b1;
            src_left[acc_r]--;
        end
        tcyc++;
        @(negedge clk);
    endtask

    task automatic start_test();
        tcyc = 0;
        prev_busy = 0;
        out_q.delete();
        exp_q.delete();
        grant_q.delete();
        full_lo = -1;
        full_hi = -1;
        rst_cyc = -1;
        refill_len = 0;
        vld_pct = 100;
        full_pct = 0;
        for (int i = 0; i < NREQ; i++) src_left[i] = 0;
    endtask

    task automatic do_reset();
        force_rst = 1;
        cycle();
        force_rst = 0;
    endtask

    task automatic check_out(input string tag);
        check_eq({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) check_eq(tag, out_q[i], exp_q[i]);
    endtask

    initial begin
        rstn = 0; rst3n = 0; wr_full = 0; wr_full3 = 0;
        req_vld = '0; req_last = '0; req_dat = '0;
        vld3 = '0; last3 = '0;
        dat3 = {16'hC002, 16'hB001, 16'hA000};
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 0;
            src_next[i] = '0;
        end
        @(negedge clk);

        // 3 requesters: 1 then {1,2} valid; pointer lands on 2, then wraps to pick 1.
        for (int c = 0; c < 9; c++) begin
            rst3n = (c != 0);
            vld3  = (c == 1 || c == 2) ? 3'b010 : (c >= 3 && c <= 7) ? 3'b110 : 3'b000;
            last3 = vld3;
            #1;
            case (c)
                1: check_eq("n3_reset_rdy", rdy3, 3'b000);
                2: begin
                    check_eq("n3_gid_first", gid3, 2'd1);
                    check_eq("n3_rdy_first", rdy3, 3'b010);
                end
                3: begin
                    check_eq("n3_idle_rdy", rdy3, 3'b000);
                    check_eq("n3_out1", {wr_ena3, wr_last3, wr_dat3}, {2'b11, 16'hB001});
                end
                4: begin
                    check_eq("n3_gid_ptr2", gid3, 2'd2);
                    check_eq("n3_rdy_ptr2", rdy3, 3'b100);
                end
                5: check_eq("n3_out2", {wr_ena3, wr_last3, wr_dat3, busy3}, {2'b11, 16'hC002, 1'b0});
                6: begin
                    check_eq("n3_gid_wrap", gid3, 2'd1);
                    check_eq("n3_rdy_wrap", rdy3, 3'b010);
                end
                7: check_eq("n3_out3", {wr_ena3, wr_last3, wr_dat3}, {2'b11, 16'hB001});
                default: ;
            endcase
            @(negedge clk);
        end

        // Single 4-beat packet from requester 0.
        start_test();
        do_reset();
        start_test();
        src_left[0] = 4;
        src_next[0] = 16'h0001;
        repeat (8) cycle();
        check_eq("single_ena_cycles", ena_h[7:0], 8'h3C);
        check_eq("single_last_cycle", last_h[7:0], 8'h20);
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, i == 4, 16'(i)});
        check_out("single_beats");

        // Pointer now 1: requester 1 wins over 0.
        start_test();
        src_left[0] = 1; src_next[0] = 16'h0005;
        src_left[1] = 1; src_next[1] = 16'h0101;
        repeat (6) cycle();
        check_eq("ptr1_first_grant", gid_h[1], 1);
        check_eq("ptr1_second_grant", gid_h[3], 0);
        exp_q.push_back({2'b01, 16'h0101});
        exp_q.push_back({2'b01, 16'h0005});
        check_out("ptr1_beats");

        // Contention: all four with back-to-back 2-beat packets.
        start_test();
        do_reset();
        start_test();
        refill_len = 2;
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 2;
            src_next[i] = 16'(i * 16'h1000);
        end
        repeat (15) cycle();
        check_eq("rr_busy_pattern", busy_h[14:0], 15'h6DB6);
        check_eq("rr_grant_count", grant_q.size(), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++) check_eq("rr_grant_order", grant_q[i], i % 4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'b00, 16'(i * 16'h1000)});
            exp_q.push_back({2'b01, 16'(i * 16'h1000 + 1)});
        end
        exp_q.push_back({2'b00, 16'h0002});
        check_out("rr_beats");

        // Backpressure for 3 cycles mid-packet.
        start_test();
        do_reset();
        start_test();
        src_left[2] = 4;
        src_next[2] = 16'h2200;
        full_lo = 3;
        full_hi = 5;
        repeat (12) cycle();
        check_eq("bp_rdy_before", rdy_h[2], 4'b0100);
        check_eq("bp_rdy_stalled", rdy_h[3] | rdy_h[4] | rdy_h[5], 4'b0000);
        check_eq("bp_ena_cycles", ena_h[11:0], 12'h18C);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, i == 3, 16'(16'h2200 + i)});
        check_out("bp_beats");

        // Truncation at 4 beats of a 6-beat packet.
        start_test();
        do_reset();
        start_test();
        src_left[1] = 6;
        src_next[1] = 16'h0100;
        repeat (14) cycle();
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 3, i == 3 || i == 5, 16'(16'h0100 + i)});
        check_out("trunc_beats");

        // Reset after beat 2 of 5, with the pointer parked away from 0.
        start_test();
        src_left[2] = 5;
        src_next[2] = 16'h0200;
        rst_cyc = 3;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                src_left[0] = 1; src_next[0] = 16'h0A00;
                src_left[1] = 1;
                src_left[3] = 1;
            end
            cycle();
        end
        check_eq("rst_outputs", {busy_h[4], ena_h[4], last_h[4], rdy_h[4]}, 7'b0);
        check_eq("rst_gid", gid_h[4], 0);
        check_eq("rst_rearb_gid", gid_h[5], 0);
        check_eq("rst_rearb_busy", busy_h[5], 1'b1);

        // Randomized traffic, backpressure and occasional resets.
        start_test();
        rand_mode = 1;
        vld_pct = 70;
        full_pct = 20;
        repeat (3000) cycle();
        rand_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
